// File: rtl/gate_response_checker.sv
// Purpose: sweeps every input vector into a 1-output gate, samples it and checks it against TRUTH.
// Latency: 2**N_IN*SETTLE+1 cycles from accepted start to the done pulse.
// Backpressure: none; start is only honoured in IDLE, and starts during a sweep are dropped.
module gate_response_checker #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 2,
    parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int              NUM_VEC  = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(NUM_VEC);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t        state;
    logic [3:0]    settle_cnt;
    logic          expected_bit;
    logic          mismatch;
    logic [N_IN:0] err_next;

    // Compare the sampled gate output; an unknown output falls to the else
    // branch so it can never be scored as a match.
    always_comb begin
        expected_bit = TRUTH[dut_in];
        mismatch     = 1'b1;
        if (dut_out == expected_bit) begin
            mismatch = 1'b0;
        end
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + 1'b1;
        end
    end

    // Sweep controller: holds each vector SETTLE cycles, samples on the last
    // one, and publishes pass/done one cycle after the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= DRIVE;
                        busy       <= 1'b1;
                        dut_in     <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        err_count  <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= dut_in;
                        end
                        // Stop on the last vector so the counter never wraps
                        // into a second sweep.
                        if (dut_in == LAST_VEC) begin
                            state <= DONE;
                        end else begin
                            dut_in <= dut_in + 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with default parameters (AND, SETTLE=2)
    logic       rst_n, start;
    logic [3:0] gate_tt;
    logic [1:0] dut_in, fail_vec;
    logic       dut_out, busy, done, pass, fail_valid;
    logic [2:0] err_count;

    assign dut_out = gate_tt[dut_in];

    gate_response_checker #(.N_IN(2), .SETTLE(2), .TRUTH(4'b1000)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    // Instance with SETTLE=1 for back-to-back sweeps
    logic       rst_n_s1, start_s1;
    logic [3:0] gate_tt_s1;
    logic [1:0] dut_in_s1, fail_vec_s1;
    logic       dut_out_s1, busy_s1, done_s1, pass_s1, fail_valid_s1;
    logic [2:0] err_count_s1;

    assign dut_out_s1 = gate_tt_s1[dut_in_s1];

    gate_response_checker #(.N_IN(2), .SETTLE(1), .TRUTH(4'b1000)) u_dut_s1 (
        .clk        (clk),
        .rst_n      (rst_n_s1),
        .start      (start_s1),
        .dut_in     (dut_in_s1),
        .dut_out    (dut_out_s1),
        .busy       (busy_s1),
        .done       (done_s1),
        .pass       (pass_s1),
        .err_count  (err_count_s1),
        .fail_valid (fail_valid_s1),
        .fail_vec   (fail_vec_s1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk every vector, compare the gate's output against a
    // two-input AND of the vector bits.
    function automatic void model(input logic [3:0] tt, output int errs,
                                  output int first, output bit fv);
        errs  = 0;
        first = 0;
        fv    = 1'b0;
        for (int v = 0; v < 4; v++) begin
            bit got;
            bit want;
            got  = tt[v];
            want = v[1] & v[0];
            if (got != want) begin
                errs++;
                if (!fv) begin
                    fv    = 1'b1;
                    first = v;
                end
            end
        end
        if (errs > 4) errs = 4;
    endfunction

    // One full sweep on the SETTLE=2 instance; cycle k is observed 1 time
    // unit after edge k, where edge 0 accepts the start.
    task automatic sweep(input logic [3:0] tt, input bit poke);
        int errs, first;
        bit fv;
        model(tt, errs, first, fv);
        gate_tt = tt;
        start   = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #1;
            start = poke && (k == 2 || k == 8);
            chk("dut_in", 32'(dut_in), 32'((k / 2 > 3) ? 3 : k / 2));
            chk("busy",   32'(busy),   32'(k <= 8));
            chk("done",   32'(done),   32'(k == 9));
        end
        chk("pass",       32'(pass),       32'(errs == 0));
        chk("err_count",  32'(err_count),  32'(errs));
        chk("fail_valid", 32'(fail_valid), 32'(fv));
        if (fv) chk("fail_vec", 32'(fail_vec), 32'(first));
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                chk("no_restart_busy", 32'(busy), 32'd0);
                chk("no_restart_done", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        gate_tt    = 4'b1000;
        rst_n_s1   = 1'b0;
        start_s1   = 1'b0;
        gate_tt_s1 = 4'b1111;
        #1;
        chk("rst_dut_in",     32'(dut_in),     32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_pass",       32'(pass),       32'd0);
        chk("rst_err_count",  32'(err_count),  32'd0);
        chk("rst_fail_valid", 32'(fail_valid), 32'd0);
        chk("rst_fail_vec",   32'(fail_vec),   32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed: correct AND, stuck-at-0, OR in place of AND
        sweep(4'b1000, 1'b0);
        sweep(4'b0000, 1'b0);
        sweep(4'b1110, 1'b0);
        // Starts during the sweep (edges 3 and 9) are dropped
        sweep(4'b1000, 1'b1);

        // Asynchronous reset part way through a failing sweep
        gate_tt = 4'b1111;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_err_count",  32'(err_count),  32'd2);
        chk("pre_rst_fail_valid", 32'(fail_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy",       32'(busy),       32'd0);
        chk("async_rst_dut_in",     32'(dut_in),     32'd0);
        chk("async_rst_err_count",  32'(err_count),  32'd0);
        chk("async_rst_fail_valid", 32'(fail_valid), 32'd0);
        chk("async_rst_fail_vec",   32'(fail_vec),   32'd0);
        chk("async_rst_pass",       32'(pass),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        sweep(4'b1000, 1'b0);

        // Randomized gate behaviour against the reference
        repeat (8) sweep(4'($urandom_range(0, 15)), 1'b0);

        // SETTLE=1 with start held high: done every 6 cycles, stuck-at-1
        start_s1 = 1'b1;
        @(posedge clk); #1;
        rst_n_s1 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            chk("s1_done", 32'(done_s1), 32'(k % 6 == 5));
            chk("s1_busy", 32'(busy_s1), 32'(k % 6 <= 4));
            chk("s1_err_le4", 32'(err_count_s1 <= 3'd4), 32'd1);
            if (k % 6 == 5) begin
                chk("s1_err_count",  32'(err_count_s1),  32'd3);
                chk("s1_pass",       32'(pass_s1),       32'd0);
                chk("s1_fail_valid", 32'(fail_valid_s1), 32'd1);
                chk("s1_fail_vec",   32'(fail_vec_s1),   32'd0);
            end
        end
        start_s1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
